// File: rtl/shift_reg_engine.sv
// Parametrised shift/rotate register with manual stepping, serial in/out and an
// autonomous run counter that shifts `count` times after `start`, then pulses `done`.
module shift_reg_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load_en,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  input  logic             step,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] op,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // valid/ready: none; load_en/start/step are single-cycle strobes sampled on
  // the rising edge, busy is level status and done is a one-cycle pulse.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic             ser_out_q, ser_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_pend_q, zero_pend_d;
  logic [2:0]       run_mode_q, run_mode_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic [2:0]       shift_mode;
  logic [WIDTH-1:0] shift_op;
  logic             shift_bit;

  // One shift of the current register; hold modes leave ser_out untouched.
  always_comb begin
    shift_mode = (state_q == RUN) ? run_mode_q : mode;
    shift_op   = op_q;
    shift_bit  = ser_out_q;
    case (shift_mode)
      3'd1: begin
        shift_op  = {op_q[WIDTH-2:0], op_q[WIDTH-1]};
        shift_bit = op_q[WIDTH-1];
      end
      3'd2: begin
        shift_op  = {op_q[0], op_q[WIDTH-1:1]};
        shift_bit = op_q[0];
      end
      3'd3: begin
        shift_op  = {op_q[WIDTH-2:0], ser_in};
        shift_bit = op_q[WIDTH-1];
      end
      3'd4: begin
        shift_op  = {ser_in, op_q[WIDTH-1:1]};
        shift_bit = op_q[0];
      end
      3'd5: begin
        shift_op  = {op_q[WIDTH-1], op_q[WIDTH-1:1]};
        shift_bit = op_q[0];
      end
      default: begin
        shift_op  = op_q;
        shift_bit = ser_out_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ser_out_d   = ser_out_q;
    done_d      = zero_pend_q;
    zero_pend_d = 1'b0;
    run_mode_d  = run_mode_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          op_d = load_val;
        end else if (start) begin
          run_mode_d  = mode;
          remaining_d = count;
          // A zero-length run reports completion one cycle later without shifting.
          if (count == '0) zero_pend_d = 1'b1;
          else             state_d     = RUN;
        end else if (step) begin
          op_d      = shift_op;
          ser_out_d = shift_bit;
        end
      end
      RUN: begin
        if (load_en) begin
          op_d        = load_val;
          state_d     = IDLE;
          remaining_d = '0;
        end else begin
          op_d        = shift_op;
          ser_out_d   = shift_bit;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      op_q        <= '0;
      ser_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      zero_pend_q <= 1'b0;
      run_mode_q  <= 3'd0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ser_out_q   <= ser_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      zero_pend_q <= zero_pend_d;
      run_mode_q  <= run_mode_d;
      remaining_q <= remaining_d;
    end
  end

  assign op      = op_q;
  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_engine.sv
// Directed and randomized checks of shift_reg_engine against an arithmetic
// model of the shift rules and run timing.
module tb_shift_reg_engine;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [W-1:0]  load_val;
  logic          load_en;
  logic [2:0]    mode;
  logic          ser_in;
  logic          step;
  logic          start;
  logic [CW-1:0] count;
  logic [W-1:0]  op;
  logic          ser_out;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int m_op     = 0;
  bit m_so     = 1'b0;

  shift_reg_engine #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .load_val(load_val), .load_en(load_en),
    .mode(mode), .ser_in(ser_in), .step(step), .start(start), .count(count),
    .op(op), .ser_out(ser_out), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: one shift computed with integer arithmetic
  function automatic void model_shift(input int m, input bit si, inout int v, inout bit so);
    int mask;
    int msb;
    int lsb;
    mask = (1 << W) - 1;
    msb  = (v >> (W - 1)) & 1;
    lsb  = v & 1;
    case (m)
      1: begin so = msb[0]; v = ((v << 1) | msb) & mask; end
      2: begin so = lsb[0]; v = (v >> 1) | (lsb << (W - 1)); end
      3: begin so = msb[0]; v = ((v << 1) | int'(si)) & mask; end
      4: begin so = lsb[0]; v = (v >> 1) | (int'(si) << (W - 1)); end
      5: begin so = lsb[0]; v = (v >> 1) | (msb << (W - 1)); end
      default: ;
    endcase
  endfunction

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit exp_busy, input bit exp_done);
    check({tag, "_op"}, 32'(op), 32'(m_op));
    check({tag, "_so"}, 32'(ser_out), 32'(m_so));
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    check({tag, "_done"}, 32'(done), 32'(exp_done));
  endtask

  // driver tasks
  task automatic do_load(input int v);
    load_val = v[W-1:0];
    load_en  = 1'b1;
    tick();
    load_en  = 1'b0;
    m_op     = v & ((1 << W) - 1);
    check_all("load", 1'b0, 1'b0);
  endtask

  task automatic do_step(input int m, input bit si);
    mode   = m[2:0];
    ser_in = si;
    step   = 1'b1;
    tick();
    step   = 1'b0;
    model_shift(m, si, m_op, m_so);
    check_all("step", 1'b0, 1'b0);
  endtask

  // si_fix < 0 means a random serial bit every cycle
  task automatic do_run(input int v, input int m, input int si_fix, input int n,
                        input bit with_load, input bit poke);
    bit si;
    if (with_load) do_load(v);
    start = 1'b1;
    mode  = m[2:0];
    count = n[CW-1:0];
    tick();
    start = 1'b0;
    check_all("run_start", 1'b1, 1'b0);
    for (int i = 1; i <= n; i++) begin
      si     = (si_fix < 0) ? 1'($urandom_range(0, 1)) : si_fix[0];
      ser_in = si;
      mode   = 3'($urandom_range(0, 7));
      count  = CW'($urandom_range(0, 15));
      start  = poke && (i == 2);
      step   = poke && (i == 3);
      tick();
      start  = 1'b0;
      step   = 1'b0;
      model_shift(m, si, m_op, m_so);
      check_all("run", i < n, i == n);
    end
  endtask

  initial begin
    rstn = 1'b0; load_val = 8'hFF; load_en = 1'b1; mode = 3'd0; ser_in = 1'b0;
    step = 1'b0; start = 1'b0; count = '0;
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0);
    check("reset_op_zero", 32'(op), 32'h0);
    rstn = 1'b1;
    load_en = 1'b0;
    tick();

    // manual steps
    do_load(8'hA5);
    do_step(1, 1'b0);
    check("step_rotl", 32'(op), 32'h4B);
    check("step_rotl_so", 32'(ser_out), 32'h1);
    do_step(2, 1'b0);
    check("step_rotr", 32'(op), 32'hA5);
    check("step_rotr_so", 32'(ser_out), 32'h1);

    // full rotation, start-while-busy poke
    do_run(8'h81, 1, -1, 8, 1'b1, 1'b1);
    check("full_rot", 32'(op), 32'h81);

    // fill modes
    do_run(8'h00, 4, 1, 3, 1'b1, 1'b0);
    check("fill_shr", 32'(op), 32'hE0);
    do_run(8'h80, 5, -1, 2, 1'b1, 1'b0);
    check("fill_ashr", 32'(op), 32'hE0);
    do_run(8'h01, 3, 0, 3, 1'b1, 1'b0);
    check("fill_shl", 32'(op), 32'h08);
    check("fill_shl_so", 32'(ser_out), 32'h0);

    // start accepted in the done cycle
    do_run(0, 2, -1, 5, 1'b0, 1'b0);

    // zero-length run
    do_load(8'h5A);
    start = 1'b1; mode = 3'd1; count = '0;
    tick();
    start = 1'b0;
    check_all("zero_k", 1'b0, 1'b0);
    tick();
    check_all("zero_k1", 1'b0, 1'b1);
    tick();
    check_all("zero_k2", 1'b0, 1'b0);

    // abort by load
    do_load(8'h96);
    start = 1'b1; mode = 3'd1; count = 4'd5;
    tick();
    start = 1'b0;
    ser_in = 1'b0;
    tick();
    model_shift(1, 1'b0, m_op, m_so);
    check_all("abort_s1", 1'b1, 1'b0);
    load_val = 8'h3C; load_en = 1'b1;
    tick();
    load_en = 1'b0;
    m_op = 8'h3C;
    check_all("abort", 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all("abort_after", 1'b0, 1'b0);
    end

    // mid-run reset
    do_load(8'h77);
    start = 1'b1; mode = 3'd2; count = 4'd6;
    tick();
    start = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_op = 0;
    m_so = 1'b0;
    check_all("midrst", 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all("midrst_after", 1'b0, 1'b0);
    end

    // randomized mix
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0: do_step(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        1: do_run(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), -1,
                  int'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: do_load(int'($urandom_range(0, 255)));
      endcase
    end
    tick();
    check_all("final", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
